// File: rtl/comparator_sched.sv
// comparator_sched: round-robin scheduler sharing one WIDTH-bit comparator
// among NREQ requesters. One operation in flight: accept an operand pair,
// hold it on cmp_a/cmp_b for CMP_LAT cycles, capture cmp_q, then return the
// result to the owning requester over a valid/ready handshake.
module comparator_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CMP_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  input  logic                  cmp_q,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_q,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  busy
);

  localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(CMP_LAT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic             gnt_any;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             dec;
  logic             capture;
  logic             done;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  // Unpack the flat operand buses into per-requester lanes
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; req_ready is a combinational grant in IDLE
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    dec       = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          req_ready[gnt_id] = 1'b1;
          accept            = 1'b1;
          state_nxt         = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[cur_id]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand hold, latency counter, result capture and pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_a     <= '0;
      cmp_b     <= '0;
      cur_id    <= '0;
      cnt       <= '0;
      rr_ptr    <= '0;
      rsp_q     <= 1'b0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        cmp_a  <= a_arr[gnt_id];
        cmp_b  <= b_arr[gnt_id];
        cur_id <= gnt_id;
        cnt    <= CNT_W'(CMP_LAT - 1);
      end else if (dec) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_q     <= cmp_q;
        rsp_valid <= NREQ'(1) << cur_id;
      end
      if (done) begin
        rsp_valid <= '0;
        rr_ptr    <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + ID_W'(1);
      end
      busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_comparator_sched.sv
// Bench for comparator_sched: transaction-level reference model compared
// against the DUT every cycle, plus directed literal checks.
module tb_comparator_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CMP_LAT = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      cmp_a;
  logic [WIDTH-1:0]      cmp_b;
  logic                  cmp_q;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_q;
  logic [NREQ-1:0]       rsp_ready;
  logic                  busy;
  logic                  cmp_pipe = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  comparator_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CMP_LAT(CMP_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_q(cmp_q),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  // Shared comparator (unsigned a<b): one register after the registered operands,
  // so the result is ready two cycles after accept
  always @(posedge clk) cmp_pipe <= (cmp_a < cmp_b);
  assign cmp_q = cmp_pipe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] op_of(input logic [NREQ*WIDTH-1:0] v, input int i);
    return v[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rop();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Reference model: one transaction in flight, tracked by its age in cycles
  bit               m_busy;
  int               m_age;
  int               m_owner;
  int               m_rr;
  logic [WIDTH-1:0] m_ca, m_cb;
  bit               m_res;
  bit               m_q_last;
  int               e_g;
  bit               e_resp;
  logic [NREQ-1:0]  e_rdy, e_rv;

  // Per-cycle compare of every output against the model, then advance the model
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_owner = 0; m_rr = 0;
      m_ca = '0; m_cb = '0; m_res = 0; m_q_last = 0;
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cmp_a", 32'(cmp_a), 32'(0));
      chk("rst_cmp_b", 32'(cmp_b), 32'(0));
      chk("rst_rsp_q", 32'(rsp_q), 32'(0));
    end else begin
      e_g    = m_busy ? -1 : pick(req_valid, m_rr);
      e_rdy  = (e_g >= 0) ? (NREQ'(1) << e_g) : '0;
      e_resp = m_busy && (m_age >= CMP_LAT + 1);
      e_rv   = e_resp ? (NREQ'(1) << m_owner) : '0;
      chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_cmp_a", 32'(cmp_a), 32'(m_ca));
      chk("m_cmp_b", 32'(cmp_b), 32'(m_cb));
      chk("m_rsp_q", 32'(rsp_q), 32'(e_resp ? m_res : m_q_last));
      if (e_g >= 0) begin
        m_busy = 1; m_age = 1; m_owner = e_g;
        m_ca = op_of(req_a, e_g); m_cb = op_of(req_b, e_g);
        m_res = (m_ca < m_cb);
      end else if (e_resp && rsp_ready[m_owner]) begin
        m_busy = 0; m_rr = (m_owner + 1) % NREQ; m_q_last = m_res;
      end else if (m_busy) begin
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, rop(), rop());
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 20) begin tick(); k++; end
    if (busy) chk({tag, "_timeout"}, 32'(busy), 32'(0));
  endtask

  // One operation from IDLE with literal expectations for grant, operands and result
  task automatic do_op(input string tag, input logic [NREQ-1:0] v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input int exp_g, input bit exp_q);
    tick();
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) if (v[i]) set_op(i, a, b);
    req_valid = v;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(NREQ'(1) << exp_g));
    tick();
    req_valid = '0;
    rand_ops();
    chk({tag, "_cmp_a1"}, 32'(cmp_a), 32'(a));
    chk({tag, "_cmp_b1"}, 32'(cmp_b), 32'(b));
    tick();
    chk({tag, "_cmp_a2"}, 32'(cmp_a), 32'(a));
    chk({tag, "_cmp_b2"}, 32'(cmp_b), 32'(b));
    chk({tag, "_rv_early"}, 32'(rsp_valid), 32'(0));
    tick();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(NREQ'(1) << exp_g));
    chk({tag, "_rsp_q"}, 32'(rsp_q), 32'(exp_q));
    wait_idle(tag);
  endtask

  int exp_order [5] = '{1, 2, 3, 0, 1};
  int gcnt, last_c;
  logic [NREQ-1:0] sv_rv;
  logic            sv_q;

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single op from requester 0
    tick();
    set_op(0, 8'h35, 8'h7A); req_valid = 4'b0001; rsp_ready = '1;
    #1 chk("t1_req_ready", 32'(req_ready), 32'(4'b0001));
    tick(); req_valid = '0;
    chk("t1_cmp_a", 32'(cmp_a), 32'(8'h35));
    chk("t1_cmp_b", 32'(cmp_b), 32'(8'h7A));
    chk("t1_busy", 32'(busy), 32'(1));
    tick(); chk("t1_rv_t2", 32'(rsp_valid), 32'(0));
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    chk("t1_rsp_q", 32'(rsp_q), 32'(1));
    tick();
    chk("t1_idle_busy", 32'(busy), 32'(0));
    chk("t1_idle_rv", 32'(rsp_valid), 32'(0));

    // Contention: all requesting, rr_ptr=1 after serving 0
    req_valid = '1; gcnt = 0; last_c = 0;
    for (int c = 0; c < 40 && gcnt < 5; c++) begin
      rand_ops();
      #1;
      if (req_ready != '0) begin
        chk("t2_order", 32'(oh2i(req_ready)), 32'(exp_order[gcnt]));
        if (gcnt > 0) chk("t2_spacing", 32'(c - last_c), 32'(CMP_LAT + 2));
        last_c = c; gcnt++;
      end
      tick();
    end
    if (gcnt < 5) chk("t2_grant_count", 32'(gcnt), 32'(5));
    req_valid = '0;
    wait_idle("t2");

    // Backpressure in RESP; requester 0 granted from rr_ptr=2
    tick();
    rsp_ready = '0; set_op(0, rop(), rop()); req_valid = 4'b0001;
    #1 chk("t3_grant", 32'(req_ready), 32'(4'b0001));
    tick(); req_valid = '1;
    for (int k = 0; k < 10 && rsp_valid == '0; k++) tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    sv_rv = rsp_valid; sv_q = rsp_q;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_rv", 32'(rsp_valid), 32'(sv_rv));
      chk("t3_hold_q", 32'(rsp_q), 32'(sv_q));
      chk("t3_no_grant", 32'(req_ready), 32'(0));
      rsp_ready = (i < 3) ? 4'b0000 : 4'b1110;
      tick();
    end
    chk("t3_still_resp", 32'(rsp_valid), 32'(sv_rv));
    req_valid = '0; rsp_ready = 4'b0001;
    tick();
    chk("t3_idle", 32'(busy), 32'(0));
    chk("t3_rv_clear", 32'(rsp_valid), 32'(0));

    // Wrap: rr_ptr=1 -> serve 3, then 2, then 3 before 0
    do_op("t4a", 4'b1000, 8'h10, 8'h20, 3, 1'b1);
    do_op("t4b", 4'b0100, 8'h20, 8'h10, 2, 1'b0);
    do_op("t4c", 4'b1001, 8'h55, 8'h55, 3, 1'b0);

    // Async reset during WAIT
    tick();
    rsp_ready = '1; set_op(2, 8'hA5, 8'h5A); req_valid = 4'b0100;
    tick(); req_valid = '0;
    #1 rst = 1'b1;
    #1;
    chk("t5_cmp_a", 32'(cmp_a), 32'(0));
    chk("t5_cmp_b", 32'(cmp_b), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("t5_req_ready", 32'(req_ready), 32'(0));
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rsp", 32'(rsp_valid), 32'(0));
    end
    do_op("t5_grant1", 4'b0010, 8'h01, 8'h02, 1, 1'b1);

    // Extreme operands
    do_op("t6a", 4'b0001, 8'h00, 8'hFF, 0, 1'b1);
    do_op("t6b", 4'b0001, 8'hFF, 8'h00, 0, 1'b0);
    do_op("t6c", 4'b0001, 8'hFF, 8'hFF, 0, 1'b0);

    // Random traffic with one reset pulse in the middle
    for (int c = 0; c < 800; c++) begin
      tick();
      rand_ops();
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      if (c == 400) rst = 1'b1;
      if (c == 402) rst = 1'b0;
    end
    tick();
    req_valid = '0; rsp_ready = '1;
    tick();
    wait_idle("final");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
